// File: rtl/armleocpu_tlb_sa.sv
// Set-associative TLB: per-set victim pointers, registered resolve result, sequential flush FSM.
// Optional hit/miss performance counters are enabled by defining ARMLEOCPU_TLB_PERF_EN.
module armleocpu_tlb_sa #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        resolve,
  input  logic        write,
  input  logic        invalidate,
  input  logic [19:0] virtual_address,
  input  logic [21:0] phys_w,
  input  logic [7:0]  accesstag_w,
  output logic        done,
  output logic        miss,
  output logic [21:0] phys_r,
  output logic [7:0]  accesstag_r,
  output logic        busy
`ifdef ARMLEOCPU_TLB_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int SETS  = 1 << ENTRIES_W;
  localparam int TAG_W = 20 - ENTRIES_W;
  localparam int VP_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t state_reg, state_next;
  logic [ENTRIES_W-1:0] flush_cnt_reg;

  logic [WAYS-1:0]  valid_reg [SETS];
  logic [VP_W-1:0]  vp_reg    [SETS];
  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [21:0]      phys_mem  [SETS][WAYS];
  logic [7:0]       at_mem    [SETS][WAYS];

  logic        done_reg, miss_reg;
  logic [21:0] phys_reg;
  logic [7:0]  at_reg;

  logic [ENTRIES_W-1:0] idx;
  logic [TAG_W-1:0]     va_tag;
  logic                 idle, accept_inv, accept_wr, accept_rd;

  assign idx        = virtual_address[ENTRIES_W-1:0];
  assign va_tag     = virtual_address[19:ENTRIES_W];
  assign idle       = (state_reg == IDLE);
  assign accept_inv = idle && invalidate;
  assign accept_wr  = idle && write && !invalidate;
  assign accept_rd  = idle && resolve && !write && !invalidate;

  logic [WAYS-1:0] tag_eq, way_valid;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign tag_eq[gi]    = (tag_mem[idx][gi] == va_tag);
      assign way_valid[gi] = valid_reg[idx][gi];
    end
  endgenerate

  logic            hit, match_found, inv_found, evict;
  logic [VP_W-1:0] hit_way, match_way, inv_way, wr_way, vp_inc;

  // Lowest-index way wins for hit, tag match and free-slot search alike.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    match_found = 1'b0;
    match_way   = '0;
    inv_found   = 1'b0;
    inv_way     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && tag_eq[w] && way_valid[w]) begin
        hit     = 1'b1;
        hit_way = VP_W'(w);
      end
      if (!match_found && tag_eq[w]) begin
        match_found = 1'b1;
        match_way   = VP_W'(w);
      end
      if (!inv_found && !way_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = VP_W'(w);
      end
    end
    evict  = 1'b0;
    vp_inc = (vp_reg[idx] == VP_W'(WAYS - 1)) ? '0 : vp_reg[idx] + 1'b1;
    if (match_found)
      wr_way = match_way;
    else if (inv_found)
      wr_way = inv_way;
    else begin
      wr_way = vp_reg[idx];
      evict  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: if (invalidate) state_next = FLUSH;
      FLUSH: begin
        busy = 1'b1;
        if (&flush_cnt_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Valid bits and victim pointers carry reset; payload storage does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        vp_reg[s]    <= '0;
      end
      flush_cnt_reg <= '0;
    end else if (accept_inv) begin
      flush_cnt_reg <= '0;
    end else if (state_reg == FLUSH) begin
      valid_reg[flush_cnt_reg] <= '0;
      vp_reg[flush_cnt_reg]    <= '0;
      flush_cnt_reg            <= flush_cnt_reg + 1'b1;
    end else if (accept_wr) begin
      valid_reg[idx][wr_way] <= accesstag_w[0];
      if (evict) vp_reg[idx] <= vp_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_wr) begin
      tag_mem[idx][wr_way]  <= va_tag;
      phys_mem[idx][wr_way] <= phys_w;
      at_mem[idx][wr_way]   <= accesstag_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg <= 1'b0;
      miss_reg <= 1'b0;
      phys_reg <= '0;
      at_reg   <= '0;
    end else begin
      done_reg <= accept_rd;
      if (accept_rd) begin
        if (!enable) begin
          miss_reg <= 1'b0;
          phys_reg <= {2'b00, virtual_address};
          at_reg   <= 8'h00;
        end else if (hit) begin
          miss_reg <= 1'b0;
          phys_reg <= phys_mem[idx][hit_way];
          at_reg   <= at_mem[idx][hit_way];
        end else begin
          miss_reg <= 1'b1;
          phys_reg <= '0;
          at_reg   <= '0;
        end
      end
    end
  end

  assign done        = done_reg;
  assign miss        = miss_reg;
  assign phys_r      = phys_reg;
  assign accesstag_r = at_reg;

`ifdef ARMLEOCPU_TLB_PERF_EN
  logic [31:0] hit_count_reg, miss_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (accept_rd && enable) begin
      if (hit)
        hit_count_reg <= hit_count_reg + 32'd1;
      else
        miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule
